// File: rtl/alarm_melody_sequencer.sv
// Alarm melody sequencer: plays an 8-note ROM melody with gaps, pauses and repeats.
// Optional snooze state is compiled in when ALARM_SNOOZE_EN is defined.
module alarm_melody_sequencer #(
    parameter int unsigned TICK_DIV     = 100000,
    parameter int unsigned GAP_TICKS    = 20,
    parameter int unsigned PAUSE_TICKS  = 500,
    parameter int unsigned REPEATS      = 4,
    parameter int unsigned SNOOZE_TICKS = 300000
) (
    input  logic        CLK100MHZ,
    input  logic        CPU_RESETN,
    input  logic        start,
    input  logic        stop,
    input  logic        snooze,
    output logic [16:0] half_period,
    output logic        tone_en,
    output logic        AUD_SD,
    output logic        busy,
    output logic [2:0]  note_idx,
    output logic        done
);

    localparam int unsigned HPW   = 17;
    localparam int unsigned IW    = 3;
    localparam int unsigned RW    = 8;
    localparam int unsigned TW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned MAX_A = (GAP_TICKS > PAUSE_TICKS) ? GAP_TICKS : PAUSE_TICKS;
    localparam int unsigned MAX_B = (MAX_A > SNOOZE_TICKS) ? MAX_A : SNOOZE_TICKS;
    localparam int unsigned MAX_D = (MAX_B > 400) ? MAX_B : 400;
    localparam int unsigned DW    = $clog2(MAX_D + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_NOTE   = 3'd1;
    localparam logic [2:0] S_GAP    = 3'd2;
    localparam logic [2:0] S_PAUSE  = 3'd3;
`ifdef ALARM_SNOOZE_EN
    localparam logic [2:0] S_SNOOZE = 3'd4;
`else
    logic snooze_unused;
    assign snooze_unused = snooze;
`endif

    // Melody ROM: tone half-period in clocks (0 = rest) and duration in ticks
    function automatic logic [HPW-1:0] rom_hp(input logic [IW-1:0] i);
        case (i)
            3'd0:    rom_hp = 17'd113636;
            3'd1:    rom_hp = 17'd95557;
            3'd2:    rom_hp = 17'd75843;
            3'd3:    rom_hp = 17'd56818;
            3'd4:    rom_hp = 17'd0;
            3'd5:    rom_hp = 17'd75843;
            3'd6:    rom_hp = 17'd95557;
            default: rom_hp = 17'd113636;
        endcase
    endfunction

    function automatic logic [8:0] rom_ticks(input logic [IW-1:0] i);
        case (i)
            3'd3:    rom_ticks = 9'd300;
            3'd4:    rom_ticks = 9'd100;
            3'd7:    rom_ticks = 9'd400;
            default: rom_ticks = 9'd150;
        endcase
    endfunction

    logic [2:0]     state, state_n;
    logic [TW-1:0]  tick_cnt;
    logic [DW-1:0]  dur_cnt;
    logic [RW-1:0]  rep_cnt, rep_n, rep_inc_c;
    logic [HPW-1:0] hp_n;
    logic [IW-1:0]  idx_n, load_idx_c;
    logic           tone_n, aud_n, busy_n, done_n;
    logic           enter_c, load_note_c, tick_c, last_c;
    logic [DW-1:0]  target_c;

    assign tick_c = (tick_cnt == TW'(TICK_DIV - 1));

    always_comb begin
        target_c = '0;
        case (state)
            S_NOTE:   target_c = DW'(rom_ticks(note_idx));
            S_GAP:    target_c = DW'(GAP_TICKS);
            S_PAUSE:  target_c = DW'(PAUSE_TICKS);
`ifdef ALARM_SNOOZE_EN
            S_SNOOZE: target_c = DW'(SNOOZE_TICKS);
`endif
            default:  target_c = '0;
        endcase
    end

    assign last_c = tick_c && (dur_cnt == target_c - DW'(1));

    // Next state and next registered outputs; priority stop > snooze > timers
    always_comb begin
        state_n     = state;
        hp_n        = half_period;
        tone_n      = tone_en;
        aud_n       = AUD_SD;
        busy_n      = busy;
        idx_n       = note_idx;
        done_n      = 1'b0;
        rep_n       = rep_cnt;
        enter_c     = 1'b0;
        load_note_c = 1'b0;
        load_idx_c  = '0;
        rep_inc_c   = (rep_cnt == '1) ? rep_cnt : rep_cnt + RW'(1);

        case (state)
            S_IDLE: begin
                if (start) begin
                    load_note_c = 1'b1;
                    rep_n       = '0;
                end
            end
            S_NOTE: begin
                if (last_c) begin
                    state_n = S_GAP;
                    tone_n  = 1'b0;
                    enter_c = 1'b1;
                end
            end
            S_GAP: begin
                if (last_c) begin
                    if (note_idx != 3'd7) begin
                        load_note_c = 1'b1;
                        load_idx_c  = note_idx + IW'(1);
                    end else if ((REPEATS != 0) && (rep_inc_c == RW'(REPEATS))) begin
                        state_n = S_IDLE;
                        hp_n    = '0;
                        tone_n  = 1'b0;
                        aud_n   = 1'b0;
                        busy_n  = 1'b0;
                        idx_n   = '0;
                        done_n  = 1'b1;
                        rep_n   = '0;
                        enter_c = 1'b1;
                    end else begin
                        state_n = S_PAUSE;
                        rep_n   = rep_inc_c;
                        enter_c = 1'b1;
                    end
                end
            end
            S_PAUSE: begin
                if (last_c) begin
                    load_note_c = 1'b1;
                end
            end
`ifdef ALARM_SNOOZE_EN
            S_SNOOZE: begin
                if (last_c) begin
                    load_note_c = 1'b1;
                    rep_n       = '0;
                end
            end
`endif
            default: state_n = S_IDLE;
        endcase

        if (load_note_c) begin
            state_n = S_NOTE;
            idx_n   = load_idx_c;
            hp_n    = rom_hp(load_idx_c);
            tone_n  = (rom_hp(load_idx_c) != '0);
            busy_n  = 1'b1;
            aud_n   = 1'b1;
            enter_c = 1'b1;
        end

`ifdef ALARM_SNOOZE_EN
        if (snooze && (state == S_NOTE || state == S_GAP || state == S_PAUSE)) begin
            state_n = S_SNOOZE;
            hp_n    = half_period;
            idx_n   = note_idx;
            tone_n  = 1'b0;
            busy_n  = 1'b1;
            aud_n   = 1'b1;
            done_n  = 1'b0;
            rep_n   = rep_cnt;
            enter_c = 1'b1;
        end
`endif

        if (stop) begin
            state_n = S_IDLE;
            hp_n    = '0;
            tone_n  = 1'b0;
            aud_n   = 1'b0;
            busy_n  = 1'b0;
            idx_n   = '0;
            done_n  = 1'b0;
            rep_n   = '0;
            enter_c = 1'b1;
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) begin
            state       <= S_IDLE;
            half_period <= '0;
            tone_en     <= 1'b0;
            AUD_SD      <= 1'b0;
            busy        <= 1'b0;
            note_idx    <= '0;
            done        <= 1'b0;
            rep_cnt     <= '0;
        end else begin
            state       <= state_n;
            half_period <= hp_n;
            tone_en     <= tone_n;
            AUD_SD      <= aud_n;
            busy        <= busy_n;
            note_idx    <= idx_n;
            done        <= done_n;
            rep_cnt     <= rep_n;
        end
    end

    // Interval timing restarts on every state entry so each interval is exact
    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) begin
            tick_cnt <= '0;
            dur_cnt  <= '0;
        end else if (enter_c || state == S_IDLE) begin
            tick_cnt <= '0;
            dur_cnt  <= '0;
        end else if (tick_c) begin
            tick_cnt <= '0;
            dur_cnt  <= dur_cnt + DW'(1);
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

endmodule

// File: tb/tb_alarm_melody_sequencer.sv
// Directed bench for alarm_melody_sequencer; snooze checks follow ALARM_SNOOZE_EN.
`timescale 1ns/1ps
module tb_alarm_melody_sequencer;

    localparam int TICK  = 10;
    localparam int GAP   = 2;
    localparam int PAUSE = 5;

    logic        clk = 1'b0;
    logic        rst_n, start, stop, snooze;
    logic [16:0] half_period;
    logic        tone_en, aud_sd, busy, done;
    logic [2:0]  note_idx;
    logic        start0, stop0, snooze0;
    logic [16:0] hp0;
    logic        tone0, aud0, busy0, done0;
    logic [2:0]  idx0;

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;
    int done0_cnt = 0;
    int mel_hp [8]    = '{113636, 95557, 75843, 56818, 0, 75843, 95557, 113636};
    int mel_ticks [8] = '{150, 150, 150, 300, 100, 150, 150, 400};

    alarm_melody_sequencer #(
        .TICK_DIV(TICK), .GAP_TICKS(GAP), .PAUSE_TICKS(PAUSE), .REPEATS(2), .SNOOZE_TICKS(30)
    ) dut (
        .CLK100MHZ(clk), .CPU_RESETN(rst_n), .start(start), .stop(stop), .snooze(snooze),
        .half_period(half_period), .tone_en(tone_en), .AUD_SD(aud_sd), .busy(busy),
        .note_idx(note_idx), .done(done)
    );

    // Endless-repeat instance on a faster tick so five melodies stay short
    alarm_melody_sequencer #(
        .TICK_DIV(2), .GAP_TICKS(GAP), .PAUSE_TICKS(PAUSE), .REPEATS(0), .SNOOZE_TICKS(30)
    ) dut0 (
        .CLK100MHZ(clk), .CPU_RESETN(rst_n), .start(start0), .stop(stop0), .snooze(snooze0),
        .half_period(hp0), .tone_en(tone0), .AUD_SD(aud0), .busy(busy0),
        .note_idx(idx0), .done(done0)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (done0 === 1'b1) done0_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One comparison per busy segment: number of cycles matching the expectation
    task automatic seg(input string tag, input int len, input bit exp_tone,
                       input int exp_idx, input int exp_hp, input int poke);
        int good = 0;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            if (tone_en === exp_tone && busy === 1'b1 && aud_sd === 1'b1 && done === 1'b0 &&
                (exp_idx < 0 || note_idx === 3'(exp_idx)) &&
                (exp_hp < 0 || half_period === 17'(exp_hp)))
                good++;
            start  = (i == poke);
            stop   = 1'b0;
            snooze = 1'b0;
        end
        check_val(tag, 32'(good), 32'(len));
    endtask

    task automatic play_melody(input int m, input bit last, input int skip,
                               input int poke_note, input int poke_cyc);
        for (int n = 0; n < 8; n++) begin
            seg($sformatf("m%0d_note%0d", m, n), mel_ticks[n] * TICK - ((n == 0) ? skip : 0),
                mel_hp[n] != 0, n, mel_hp[n], (n == poke_note) ? poke_cyc : -1);
            seg($sformatf("m%0d_gap%0d", m, n), GAP * TICK, 1'b0, n, mel_hp[n], -1);
        end
        if (last) begin
            @(negedge clk);
            check_val($sformatf("m%0d_end_busy", m), 32'(busy), 32'd0);
            check_val($sformatf("m%0d_end_done", m), 32'(done), 32'd1);
            check_val($sformatf("m%0d_end_tone", m), 32'(tone_en), 32'd0);
            check_val($sformatf("m%0d_end_aud", m), 32'(aud_sd), 32'd0);
        end else begin
            seg($sformatf("m%0d_pause", m), PAUSE * TICK, 1'b0, 7, -1, -1);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; snooze = 1'b0;
        start0 = 1'b0; stop0 = 1'b0; snooze0 = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check_val("rst_hp", 32'(half_period), 32'd0);
        check_val("rst_tone", 32'(tone_en), 32'd0);
        check_val("rst_aud", 32'(aud_sd), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_idx", 32'(note_idx), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);

        fork
            begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                check_val("start_tone", 32'(tone_en), 32'd1);
                check_val("start_hp", 32'(half_period), 32'd113636);
                check_val("start_busy", 32'(busy), 32'd1);
                check_val("start_aud", 32'(aud_sd), 32'd1);
                check_val("start_idx", 32'(note_idx), 32'd0);
                play_melody(1, 1'b0, 1, 1, 500);
                play_melody(2, 1'b1, 0, -1, -1);
                @(negedge clk);
                check_val("done_one_cycle", 32'(done), 32'd0);
                check_val("done_count", 32'(done_cnt), 32'd1);
            end
            begin
                start0 = 1'b1;
                @(negedge clk);
                start0 = 1'b0;
                repeat (15703) @(negedge clk);
                check_val("rep0_busy", 32'(busy0), 32'd1);
                check_val("rep0_pause_tone", 32'(tone0), 32'd0);
                check_val("rep0_no_done", 32'(done0_cnt), 32'd0);
                stop0 = 1'b1;
                @(negedge clk);
                stop0 = 1'b0;
                check_val("rep0_stop_busy", 32'(busy0), 32'd0);
                check_val("rep0_stop_aud", 32'(aud0), 32'd0);
            end
        join

        // Stop in the middle of note 3
        done_cnt = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4699) @(negedge clk);
        check_val("n3_idx", 32'(note_idx), 32'd3);
        check_val("n3_tone", 32'(tone_en), 32'd1);
        check_val("n3_hp", 32'(half_period), 32'd56818);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check_val("stop_tone", 32'(tone_en), 32'd0);
        check_val("stop_busy", 32'(busy), 32'd0);
        check_val("stop_aud", 32'(aud_sd), 32'd0);
        check_val("stop_hp", 32'(half_period), 32'd0);
        check_val("stop_idx", 32'(note_idx), 32'd0);
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        check_val("stop_start_busy", 32'(busy), 32'd0);
        check_val("stop_start_tone", 32'(tone_en), 32'd0);
        repeat (20) @(negedge clk);
        check_val("stop_no_done", 32'(done_cnt), 32'd0);

        // Snooze asserted during note 2
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3099) @(negedge clk);
        check_val("n2_idx", 32'(note_idx), 32'd2);
        snooze = 1'b1;
`ifdef ALARM_SNOOZE_EN
        seg("snooze_silent", 300, 1'b0, -1, -1, -1);
        play_melody(3, 1'b0, 0, -1, -1);
        play_melody(4, 1'b1, 0, -1, -1);
        @(negedge clk);
        check_val("snooze_done_count", 32'(done_cnt), 32'd1);
`else
        @(negedge clk);
        snooze = 1'b0;
        check_val("snooze_ign_tone", 32'(tone_en), 32'd1);
        check_val("snooze_ign_idx", 32'(note_idx), 32'd2);
        check_val("snooze_ign_busy", 32'(busy), 32'd1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check_val("snooze_ign_stop", 32'(busy), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
